// File: rtl/qdma_stm_lpbk_mq_if.sv
// AXI-stream bundle shared by the H2C-side input and C2H-side output of the loopback.
interface qdma_stm_lpbk_mq_if #(
  parameter int DATA_W = 512,
  parameter int DEST_W = 16,
  parameter int MTY_W  = 6
) ();
  logic [DATA_W-1:0] tdata;
  logic [DEST_W-1:0] tdest;
  logic [MTY_W-1:0]  tmty;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tdest, tmty, tlast, tvalid, input  tready);
  modport slave  (input  tdata, tdest, tmty, tlast, tvalid, output tready);
endinterface

// File: rtl/qdma_stm_lpbk_mq.sv
// Multi-channel store-and-forward AXIS loopback: tdest-steered per-channel FIFOs,
// packet-atomic round-robin return path, per-channel drop mode, status counters.

// One channel: beat FIFO plus a count of complete packets it currently holds.
module qdma_stm_lpbk_mq_ch #(
  parameter int W     = 8,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_wr_last,
  input  logic         i_rd_en,
  input  logic         i_rd_done,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_elig
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr, r_rptr, r_pkt_cnt;

  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty   = (r_wptr == r_rptr);
  // A full FIFO is eligible even without a complete packet so oversized packets cut through.
  assign o_elig    = (r_pkt_cnt != '0) | o_full;
  assign o_rd_data = r_mem[r_rptr[AW-1:0]];

  // Storage array; no reset, stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

  // Pointers and complete-packet count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_pkt_cnt <= '0;
    end else begin
      if (i_wr_en) r_wptr <= r_wptr + 1'b1;
      if (i_rd_en) r_rptr <= r_rptr + 1'b1;
      case ({i_wr_en & i_wr_last, i_rd_done})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end
endmodule

module qdma_stm_lpbk_mq #(
  parameter int MAX_DATA_WIDTH = 512,
  parameter int TDEST_BITS     = 16,
  parameter int NUM_CH         = 4,
  parameter int DEPTH          = 64,
  parameter int CNT_WIDTH      = 32,
  parameter int TCQ            = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  qdma_stm_lpbk_mq_if.slave     in_axis,
  input  logic [NUM_CH-1:0]     drop_en,
  qdma_stm_lpbk_mq_if.master    out_axis,
  output logic [CNT_WIDTH-1:0]  stat_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  stat_drop_cnt,
  output logic [NUM_CH-1:0]     ch_occupied
);
  localparam int MTY_W = $clog2(MAX_DATA_WIDTH/8);
  localparam int CH_W  = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 16 || (NUM_CH & (NUM_CH-1)) != 0 ||
      DEPTH < 4 || (DEPTH & (DEPTH-1)) != 0 || TCQ < 0) begin : g_bad_param
    $error("qdma_stm_lpbk_mq: illegal parameter set");
  end

  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] data;
    logic [TDEST_BITS-1:0]     dest;
    logic [MTY_W-1:0]          mty;
    logic                      last;
  } beat_t;

  typedef enum logic {ST_IDLE, ST_XFER} state_t;

  // ---------------- ingress ----------------
  beat_t                  w_in_beat;
  logic [CH_W-1:0]        w_in_ch;
  logic                   w_beat_drop, w_in_hs;
  logic [NUM_CH-1:0]      r_in_pkt, r_drop;
  logic [CNT_WIDTH-1:0]   r_drop_cnt;

  // per-channel
  logic [NUM_CH-1:0]      w_wr_en, w_rd_en, w_rd_done, w_full, w_empty, w_elig;
  beat_t [NUM_CH-1:0]     w_rd_data;

  // arbiter / output
  state_t                 r_state, w_nxt_state;
  logic [CH_W-1:0]        r_grant, w_nxt_grant, r_last_grant, w_nxt_last, w_rr_sel;
  logic                   w_any_elig, w_pop, w_out_free, w_out_hs_last;
  beat_t                  w_rd_beat, r_out;
  logic                   r_out_vld, r_tail;
  logic [CNT_WIDTH-1:0]   r_pkt_stat;

  assign w_in_beat = {in_axis.tdata, in_axis.tdest, in_axis.tmty, in_axis.tlast};
  assign w_in_ch   = in_axis.tdest[CH_W-1:0];
  // Drop decision is frozen for the rest of a packet once its first beat is seen.
  assign w_beat_drop    = r_in_pkt[w_in_ch] ? r_drop[w_in_ch] : drop_en[w_in_ch];
  assign in_axis.tready = rst_n & (w_beat_drop | ~w_full[w_in_ch]);
  assign w_in_hs        = in_axis.tvalid & in_axis.tready;

  // Per-channel packet-in-progress and latched drop mode; dropped-packet counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_pkt   <= '0;
      r_drop     <= '0;
      r_drop_cnt <= '0;
    end else if (w_in_hs) begin
      r_in_pkt[w_in_ch] <= ~in_axis.tlast;
      r_drop[w_in_ch]   <= w_beat_drop;
      if (w_beat_drop & in_axis.tlast) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // Steer writes, reads and packet-complete strobes to the selected channels.
  always_comb begin
    w_wr_en   = '0;
    w_rd_en   = '0;
    w_rd_done = '0;
    w_wr_en[w_in_ch]   = w_in_hs & ~w_beat_drop;
    w_rd_en[r_grant]   = w_pop;
    w_rd_done[r_grant] = w_out_hs_last;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    qdma_stm_lpbk_mq_ch #(.W($bits(beat_t)), .DEPTH(DEPTH)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr_en[i]),
      .i_wr_data (w_in_beat),
      .i_wr_last (in_axis.tlast),
      .i_rd_en   (w_rd_en[i]),
      .i_rd_done (w_rd_done[i]),
      .o_rd_data (w_rd_data[i]),
      .o_full    (w_full[i]),
      .o_empty   (w_empty[i]),
      .o_elig    (w_elig[i])
    );
  end

  assign ch_occupied = ~w_empty;

  // ---------------- arbiter ----------------
  // Round-robin: first eligible channel strictly after the last one served.
  always_comb begin
    logic [CH_W-1:0] idx;
    idx        = '0;
    w_rr_sel   = r_last_grant;
    w_any_elig = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = r_last_grant + i[CH_W-1:0];
      if (!w_any_elig && w_elig[idx]) begin
        w_any_elig = 1'b1;
        w_rr_sel   = idx;
      end
    end
  end

  assign w_rd_beat     = w_rd_data[r_grant];
  assign w_out_free    = ~r_out_vld | out_axis.tready;
  assign w_out_hs_last = r_out_vld & out_axis.tready & r_out.last;

  // Arbiter state, grant and last-served channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= CH_W'(NUM_CH-1);
    end else begin
      r_state      <= w_nxt_state;
      r_grant      <= w_nxt_grant;
      r_last_grant <= w_nxt_last;
    end
  end

  // Next state; pops stop once the tail beat is in the output register so the
  // packet stays atomic until its tlast actually handshakes downstream.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_grant = r_grant;
    w_nxt_last  = r_last_grant;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_elig) begin
          w_nxt_state = ST_XFER;
          w_nxt_grant = w_rr_sel;
        end
      end
      ST_XFER: begin
        w_pop = ~r_tail & ~w_empty[r_grant] & w_out_free;
        if (w_out_hs_last) begin
          w_nxt_state = ST_IDLE;
          w_nxt_last  = r_grant;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // ---------------- output ----------------
  // Output register: loads whenever it is empty or being drained, holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_tail     <= 1'b0;
      r_pkt_stat <= '0;
    end else begin
      if (w_pop) begin
        r_out     <= w_rd_beat;
        r_out_vld <= 1'b1;
      end else if (out_axis.tready) begin
        r_out_vld <= 1'b0;
      end
      if (w_pop & w_rd_beat.last) r_tail <= 1'b1;
      else if (w_out_hs_last)     r_tail <= 1'b0;
      if (w_out_hs_last) r_pkt_stat <= r_pkt_stat + 1'b1;
    end
  end

  assign out_axis.tdata  = r_out.data;
  assign out_axis.tdest  = r_out.dest;
  assign out_axis.tmty   = r_out.mty;
  assign out_axis.tlast  = r_out.last;
  assign out_axis.tvalid = r_out_vld;
  assign stat_pkt_cnt    = r_pkt_stat;
  assign stat_drop_cnt   = r_drop_cnt;
endmodule
